decompress_dma: RTL and testbench

- Run-length bit-stream decompressor with an integrated byte-wide DMA RAM.
- Each accepted token (value bit + run length) expands into a run of identical bits.
- The run is appended MSB-first to a packed bitstream in the RAM, at a persistent (byte, bit) write pointer, using read-modify-write for partially filled bytes.
- A host port reads and writes the RAM while the decompressor is idle.

---
 rtl/decompress_dma_pkg.sv | 26 ++
 rtl/decompress_dma_ram.sv | 34 +++
 rtl/decompress_dma.sv | 146 ++++++++++++++
 tb/tb_decompress_dma.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decompress_dma_pkg.sv
// Shared types and constants for the run-length decompressor with its byte RAM.
package decompress_dma_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_BUF_W  = 256;

    localparam logic [31:0] RST_BYTE_IDX = 32'd0;
    localparam logic [2:0]  RST_BIT_IDX  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte mask covering bits bitIdx down to bitIdx-n+1 (n never exceeds bitIdx+1).
    function automatic logic [7:0] runMask(input logic [2:0] bitIdx, input logic [3:0] n);
        logic [8:0] hiMask;
        logic [8:0] loMask;
        hiMask = (9'd1 << ({1'b0, bitIdx} + 4'd1)) - 9'd1;
        loMask = (9'd1 << ({1'b0, bitIdx} + 4'd1 - n)) - 9'd1;
        return hiMask[7:0] ^ loMask[7:0];
    endfunction

endpackage

// File: rtl/decompress_dma_ram.sv
// Single-port byte RAM, synchronous write, registered read-before-write output.
module decompress_dma_ram
    import decompress_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem_r [0:(1<<ADDR_W)-1];

    // Storage array; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read port returns the pre-write contents when read and write coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'd0;
        end else if (rd) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/decompress_dma.sv
// Run-length token expander writing an MSB-first packed bitstream into a byte RAM.
module decompress_dma
    import decompress_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BUF_W  = DEF_BUF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              work,
    input  logic [7:0]        in1,
    input  logic [7:0]        in2,
    output logic              ready,
    output logic              done,
    output logic [BUF_W-1:0]  buffer,
    output logic [31:0]       byte_indx,
    output logic [2:0]        bit_indx,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_rd,
    input  logic              ram_wr,
    input  logic [7:0]        ram_wdata,
    output logic [7:0]        ram_rdata
);

    state_t            state_r;
    logic              runVal_r;
    logic [8:0]        rem_r;
    logic [31:0]       byteIdx_r;
    logic [2:0]        bitIdx_r;
    logic              ready_r;
    logic              done_r;
    logic [BUF_W-1:0]  buf_r;

    logic              accept_s;
    logic              hostSel_s;
    logic [8:0]        tokRem_s;
    logic [BUF_W-1:0]  tokBuf_s;
    logic [3:0]        bitsLeft_s;
    logic [3:0]        n_s;
    logic              byteEnd_s;
    logic [8:0]        remNext_s;
    logic [7:0]        mask_s;
    logic [7:0]        merged_s;
    logic [7:0]        ramQ_s;
    logic [ADDR_W-1:0] ramAddr_s;
    logic              ramRe_s;
    logic              ramWe_s;
    logic [7:0]        ramD_s;
    logic              unusedBits_s;

    assign unusedBits_s = ^in1[6:0];

    // Token decode, per-byte run slice and host/engine RAM arbitration.
    always_comb begin
        accept_s   = (state_r == IDLE) && work;
        hostSel_s  = (state_r == IDLE) && !work;
        tokRem_s   = {1'b0, in2} + 9'd1;
        tokBuf_s   = in1[7] ? ~({BUF_W{1'b1}} >> tokRem_s) : ({BUF_W{1'b1}} >> tokRem_s);
        bitsLeft_s = {1'b0, bitIdx_r} + 4'd1;
        n_s        = (rem_r < {5'd0, bitsLeft_s}) ? rem_r[3:0] : bitsLeft_s;
        byteEnd_s  = (n_s == bitsLeft_s);
        remNext_s  = rem_r - {5'd0, n_s};
        mask_s     = runMask(bitIdx_r, n_s);
        // A full byte has an all-ones mask, so stale read data is fully overwritten.
        merged_s   = runVal_r ? (ramQ_s | mask_s) : (ramQ_s & ~mask_s);
        ramAddr_s  = hostSel_s ? ram_addr  : byteIdx_r[ADDR_W-1:0];
        ramRe_s    = hostSel_s ? ram_rd    : (state_r == RD);
        ramWe_s    = hostSel_s ? ram_wr    : (state_r == WR);
        ramD_s     = hostSel_s ? ram_wdata : merged_s;
    end

    // Control FSM with write pointer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            runVal_r  <= 1'b0;
            rem_r     <= 9'd0;
            byteIdx_r <= RST_BYTE_IDX;
            bitIdx_r  <= RST_BIT_IDX;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            buf_r     <= {BUF_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        runVal_r <= in1[7];
                        rem_r    <= tokRem_s;
                        buf_r    <= tokBuf_s;
                        ready_r  <= 1'b0;
                        state_r  <= ((bitIdx_r == 3'd7) && (tokRem_s >= 9'd8)) ? WR : RD;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RD: begin
                    state_r <= WR;
                end
                WR: begin
                    rem_r <= remNext_s;
                    if (byteEnd_s) begin
                        byteIdx_r <= byteIdx_r + 32'd1;
                        bitIdx_r  <= 3'd7;
                    end else begin
                        bitIdx_r  <= bitIdx_r - n_s[2:0];
                    end
                    // A run ending mid-byte always leaves rem at zero, so only byte ends continue.
                    if (remNext_s == 9'd0) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else if (byteEnd_s && (remNext_s >= 9'd8)) begin
                        state_r <= WR;
                    end else begin
                        state_r <= RD;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign done      = done_r;
    assign buffer    = buf_r;
    assign byte_indx = byteIdx_r;
    assign bit_indx  = bitIdx_r;
    assign ram_rdata = ramQ_s;

    decompress_dma_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (ramAddr_s),
        .rd    (ramRe_s),
        .wr    (ramWe_s),
        .wdata (ramD_s),
        .rdata (ramQ_s)
    );

endmodule

// File: tb/tb_decompress_dma.sv
// Self-checking bench: fixed token table, random tokens against a bit-position model, corner sequences.
module tb_decompress_dma;

    localparam int AW  = 16;
    localparam int BW  = 256;
    localparam int PRE = 700;

    logic           clk;
    logic           rst_n;
    logic           work;
    logic [7:0]     in1;
    logic [7:0]     in2;
    logic           ready;
    logic           done;
    logic [BW-1:0]  buffer;
    logic [31:0]    byte_indx;
    logic [2:0]     bit_indx;
    logic [AW-1:0]  ram_addr;
    logic           ram_rd;
    logic           ram_wr;
    logic [7:0]     ram_wdata;
    logic [7:0]     ram_rdata;

    decompress_dma #(.ADDR_W(AW), .BUF_W(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .work      (work),
        .in1       (in1),
        .in2       (in2),
        .ready     (ready),
        .done      (done),
        .buffer    (buffer),
        .byte_indx (byte_indx),
        .bit_indx  (bit_indx),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]      mdl [0:(1<<AW)-1];
    longint unsigned mPos;

    typedef struct {
        logic [7:0]  i1;
        logic [7:0]  i2;
        bit          preWr;
        logic [15:0] preA;
        logic [7:0]  preD;
        logic [31:0] eByte;
        logic [2:0]  eBit;
        int          eLat;
        logic [15:0] cA0;
        logic [7:0]  cD0;
        logic [15:0] cA1;
        logic [7:0]  cD1;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Model: append rem copies of v at absolute bit position mPos; cost 1 cycle per whole byte, 2 per partial, +1 done.
    task automatic mdlToken(input bit v, input int rem, output int lat, output logic [255:0] eBuf);
        int i;
        int off;
        int n;
        longint unsigned p;
        lat = 1;
        i = 0;
        while (i < rem) begin
            off = int'(mPos % 8);
            n = (rem - i < 8 - off) ? rem - i : 8 - off;
            lat += (off == 0 && n == 8) ? 1 : 2;
            for (int j = 0; j < n; j++) begin
                p = mPos + longint'(j);
                mdl[int'((p >> 3) % (1 << AW))][7 - int'(p % 8)] = v;
            end
            mPos += longint'(n);
            i += n;
        end
        for (int k = 0; k < 256; k++) begin
            eBuf[255 - k] = (k < rem) ? v : ~v;
        end
    endtask

    task automatic hostWrite(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        ram_addr = a; ram_wdata = d; ram_wr = 1'b1;
        @(negedge clk);
        ram_wr = 1'b0;
        mdl[a] = d;
    endtask

    task automatic hostRead(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        ram_addr = a; ram_rd = 1'b1;
        @(negedge clk);
        d = ram_rdata;
        ram_rd = 1'b0;
    endtask

    // Issue one token and count cycles to done; disturb adds host/work traffic in the accept and a busy cycle.
    task automatic runToken(input logic [7:0] i1, input logic [7:0] i2, input bit disturb, output int lat);
        @(negedge clk);
        in1 = i1; in2 = i2; work = 1'b1;
        if (disturb) begin
            ram_addr = 16'd691; ram_wdata = 8'h55; ram_wr = 1'b1;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            work = 1'b0; ram_wr = 1'b0; ram_rd = 1'b0;
            if (disturb && lat == 2) begin
                work = 1'b1; in1 = 8'h00; in2 = 8'h07;
                ram_addr = 16'd690; ram_wdata = 8'hAA; ram_wr = 1'b1; ram_rd = 1'b1;
            end
        end while (done !== 1'b1 && lat < 400);
        work = 1'b0; ram_wr = 1'b0; ram_rd = 1'b0;
    endtask

    task automatic checkAfter(input string tag, input int lat, input int eLat, input logic [255:0] eBuf);
        chk({tag, "_lat"}, lat, eLat);
        chk({tag, "_byte"}, byte_indx, 32'(mPos >> 3));
        chk({tag, "_bit"}, bit_indx, 3'(7 - (mPos % 8)));
        chk({tag, "_buf"}, buffer, eBuf);
        @(negedge clk);
        chk({tag, "_donepulse"}, done, 1'b0);
        chk({tag, "_ready"}, ready, 1'b1);
    endtask

    initial begin
        int          lat;
        int          mLat;
        logic [255:0] eBuf;
        logic [7:0]  rd;
        int          firstByte;

        rst_n = 1'b0; work = 1'b0; in1 = 8'h00; in2 = 8'h00;
        ram_addr = '0; ram_rd = 1'b0; ram_wr = 1'b0; ram_wdata = 8'h00;
        mPos = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_byte", byte_indx, 32'd0);
        chk("rst_bit", bit_indx, 3'd7);
        chk("rst_buf", buffer, 256'd0);
        chk("rst_rdata", ram_rdata, 8'h00);

        for (int a = 0; a < PRE; a++) hostWrite(16'(a), 8'h00);
        hostWrite(16'd34, 8'h35);

        tbl[0] = '{8'h80, 8'd2,   1'b0, 16'd0, 8'h00, 32'd0,  3'd4, 3,  16'd0,  8'hE0, 16'd1,  8'h00};
        tbl[1] = '{8'h80, 8'd12,  1'b0, 16'd0, 8'h00, 32'd2,  3'd7, 4,  16'd0,  8'hFF, 16'd1,  8'hFF};
        tbl[2] = '{8'h00, 8'h00,  1'b1, 16'd2, 8'hFF, 32'd2,  3'd6, 3,  16'd2,  8'h7F, 16'd1,  8'hFF};
        tbl[3] = '{8'h80, 8'hFF,  1'b0, 16'd0, 8'h00, 32'd34, 3'd6, 36, 16'd33, 8'hFF, 16'd34, 8'hB5};

        for (int t = 0; t < 4; t++) begin
            if (tbl[t].preWr) hostWrite(tbl[t].preA, tbl[t].preD);
            mdlToken(tbl[t].i1[7], int'(tbl[t].i2) + 1, mLat, eBuf);
            runToken(tbl[t].i1, tbl[t].i2, 1'b0, lat);
            chk($sformatf("tbl%0d_lat", t), lat, tbl[t].eLat);
            chk($sformatf("tbl%0d_byte", t), byte_indx, tbl[t].eByte);
            chk($sformatf("tbl%0d_bit", t), bit_indx, tbl[t].eBit);
            chk($sformatf("tbl%0d_buf", t), buffer, eBuf);
            hostRead(tbl[t].cA0, rd);
            chk($sformatf("tbl%0d_ram%0d", t, tbl[t].cA0), rd, tbl[t].cD0);
            hostRead(tbl[t].cA1, rd);
            chk($sformatf("tbl%0d_ram%0d", t, tbl[t].cA1), rd, tbl[t].cD1);
        end

        for (int t = 0; t < 15; t++) begin
            logic [7:0] r1;
            logic [7:0] r2;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                hostWrite(16'((mPos >> 3) + longint'($urandom_range(0, 3))), 8'($urandom));
            mdlToken(r1[7], int'(r2) + 1, mLat, eBuf);
            runToken(r1, r2, 1'b0, lat);
            checkAfter($sformatf("rnd%0d", t), lat, mLat, eBuf);
        end

        mdlToken(1'b1, 41, mLat, eBuf);
        runToken(8'h80, 8'd40, 1'b1, lat);
        checkAfter("busy", lat, mLat, eBuf);
        hostRead(16'd690, rd);
        chk("busy_hostwr_ignored", rd, mdl[690]);
        hostRead(16'd691, rd);
        chk("accept_hostwr_ignored", rd, mdl[691]);

        for (int a = 0; a < PRE; a++) begin
            hostRead(16'(a), rd);
            chk($sformatf("scan%0d", a), rd, mdl[a]);
        end

        firstByte = int'((mPos >> 3) % (1 << AW));
        mdlToken(1'b1, 200, mLat, eBuf);
        @(negedge clk);
        in1 = 8'h80; in2 = 8'd199; work = 1'b1;
        @(negedge clk);
        work = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_busy", ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_byte", byte_indx, 32'd0);
        chk("midrst_bit", bit_indx, 3'd7);
        chk("midrst_buf", buffer, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mPos = 0;
        hostRead(16'(firstByte), rd);
        chk("midrst_persist", rd, mdl[firstByte]);

        mdlToken(1'b0, 4, mLat, eBuf);
        runToken(8'h00, 8'd3, 1'b0, lat);
        checkAfter("postrst", lat, mLat, eBuf);
        hostRead(16'd0, rd);
        chk("postrst_ram0", rd, mdl[0]);
        chk("postrst_ram0_const", rd, 8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
